// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   S_IDLE / S_RUN / S_DONE : FSM state encodings (2-bit, legacy-compatible)
//   DEFAULT_WIDTH           : default operand width
package seq_multiplier_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/adder_nbit.sv
// Ripple-carry adder built from a chain of full-adder cells.
// Ports:
//   S   [WIDTH]  sum
//   C_O          carry out of the top cell
//   A   [WIDTH]  addend
//   B   [WIDTH]  addend
//   C_I          carry into bit 0
module adder_nbit #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] S,
  output logic             C_O,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_I
);

  logic [WIDTH:0] c;

  assign c[0] = C_I;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    // One full-adder cell per bit.
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign C_O = c[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial-product step per clock, WIDTH
// steps per operation, 2*WIDTH-bit result.
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request, honoured only while idle
//   A        multiplicand, captured on the accepting edge
//   B        multiplier, captured on the accepting edge
//   busy     high whenever an operation is in flight (RUN or DONE)
//   done     one-cycle strobe, product valid while high
//   product  accumulator contents; equals A*B while done is high
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;

  // The low half of acc holds the not-yet-consumed multiplier bits; bit 0
  // selects whether this step adds the multiplicand into the high half.
  assign addend = acc[0] ? mcand : '0;

  adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .S   (sum),
    .C_O (carry),
    .A   (acc[2*WIDTH-1:WIDTH]),
    .B   (addend),
    .C_I (1'b0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      mcand <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= A;
            acc   <= {{WIDTH{1'b0}}, B};
            count <= CW'(WIDTH);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Carry lands in the MSB so no product bit is ever lost; the
          // consumed multiplier bit falls off the bottom.
          acc   <= {carry, sum, acc[WIDTH-1:1]};
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign product = acc;

endmodule
